event_delay_scheduler: RTL and testbench

EVENT_DELAY_SCHEDULER -- requirements
Module: event_delay_scheduler

---
 rtl/event_delay_scheduler_pkg.sv | 22 ++
 rtl/event_delay_scheduler_edge_detect.sv | 50 +++++
 rtl/event_delay_scheduler.sv | 134 +++++++++++++
 tb/tb_event_delay_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/event_delay_scheduler_pkg.sv
// ============================================================================
// Package  : event_sched_pkg
// Brief    : Shared types and default sizing for the event delay scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package event_sched_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2,
        ANY  = 2'd3
    } edge_sel_e;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CW    = 8;

endpackage

`default_nettype wire

// File: rtl/event_delay_scheduler_edge_detect.sv
// ============================================================================
// Module   : event_edge_detect
// Brief    : Samples the monitored signal and qualifies edges against edge_sel/iff_en.
// Revision : 1.0
// ============================================================================
`default_nettype none

module event_edge_detect
    import event_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_in,
    input  logic [1:0] edge_sel,
    input  logic       iff_en,
    output logic       accept
);

    logic sig_d_q;
    logic sig_d_d;
    logic pos;
    logic neg;
    logic match;

    always_comb begin
        sig_d_d = sig_in;
        pos     = sig_in & ~sig_d_q;
        neg     = ~sig_in & sig_d_q;
        match   = 1'b0;
        case (edge_sel_e'(edge_sel))
            POS:     match = pos;
            NEG:     match = neg;
            ANY:     match = pos | neg;
            default: match = 1'b0;
        endcase
        accept = iff_en & match;
    end

    // Cleared on reset so a high input right after release reads as a rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_d_q <= 1'b0;
        end else begin
            sig_d_q <= sig_d_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/event_delay_scheduler.sv
// ============================================================================
// Module   : event_delay_scheduler
// Brief    : Delays qualified edge events by a per-event cycle count using a slot array.
// Revision : 1.0
// ============================================================================
`default_nettype none

module event_delay_scheduler
    import event_sched_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    parameter  int CW    = DEFAULT_CW,
    localparam int FCW   = $clog2(DEPTH + 2),
    localparam int PW    = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sig_in,
    input  logic [1:0]     edge_sel,
    input  logic           iff_en,
    input  logic [CW-1:0]  delay_val,
    input  logic           clr_drop,
    output logic           fire,
    output logic [FCW-1:0] fire_cnt,
    output logic [PW-1:0]  pending,
    output logic           drop
);

    logic             accept;
    logic [DEPTH-1:0] slot_vld_q;
    logic [DEPTH-1:0] slot_vld_d;
    logic [CW-1:0]    slot_cnt_q [DEPTH];
    logic [CW-1:0]    slot_cnt_d [DEPTH];
    logic             fire_q;
    logic             fire_d;
    logic [FCW-1:0]   fire_cnt_q;
    logic [FCW-1:0]   fire_cnt_d;
    logic [PW-1:0]    pending_q;
    logic [PW-1:0]    pending_d;
    logic             drop_q;
    logic             drop_d;
    logic             alloc_done;
    logic             discard;

    event_edge_detect u_edge_detect (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .edge_sel (edge_sel),
        .iff_en   (iff_en),
        .accept   (accept)
    );

    always_comb begin
        slot_vld_d = slot_vld_q;
        slot_cnt_d = slot_cnt_q;
        fire_cnt_d = '0;
        pending_d  = '0;
        alloc_done = 1'b0;
        discard    = 1'b0;

        if (accept && (delay_val == '0)) begin
            fire_cnt_d = FCW'(1);
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld_q[i]) begin
                if (slot_cnt_q[i] == CW'(1)) begin
                    slot_vld_d[i] = 1'b0;
                    slot_cnt_d[i] = '0;
                    fire_cnt_d    = fire_cnt_d + FCW'(1);
                end else begin
                    slot_cnt_d[i] = slot_cnt_q[i] - CW'(1);
                end
            end
        end

        // Free slots are judged on pre-edge occupancy, so an expiring slot is not reused this edge.
        if (accept && (delay_val != '0)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!slot_vld_q[i] && !alloc_done) begin
                    slot_vld_d[i] = 1'b1;
                    slot_cnt_d[i] = delay_val;
                    alloc_done    = 1'b1;
                end
            end
            discard = !alloc_done;
        end

        for (int i = 0; i < DEPTH; i++) begin
            pending_d = pending_d + PW'(slot_vld_d[i]);
        end

        fire_d = (fire_cnt_d != '0);

        if (discard) begin
            drop_d = 1'b1;
        end else if (clr_drop) begin
            drop_d = 1'b0;
        end else begin
            drop_d = drop_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_cnt_q[i] <= '0;
            end
            fire_q     <= 1'b0;
            fire_cnt_q <= '0;
            pending_q  <= '0;
            drop_q     <= 1'b0;
        end else begin
            slot_vld_q <= slot_vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                slot_cnt_q[i] <= slot_cnt_d[i];
            end
            fire_q     <= fire_d;
            fire_cnt_q <= fire_cnt_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
        end
    end

    assign fire     = fire_q;
    assign fire_cnt = fire_cnt_q;
    assign pending  = pending_q;
    assign drop     = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_event_delay_scheduler.sv
// ============================================================================
// Module   : tb_event_delay_scheduler
// Brief    : Directed and random stimulus with a queue-based scoreboard of expected expiries.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_event_delay_scheduler;

    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int FCW   = $clog2(DEPTH + 2);
    localparam int PW    = $clog2(DEPTH + 1);

    localparam logic [1:0] S_NONE = 2'd0;
    localparam logic [1:0] S_POS  = 2'd1;
    localparam logic [1:0] S_NEG  = 2'd2;
    localparam logic [1:0] S_ANY  = 2'd3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           sig_in = 1'b0;
    logic [1:0]     edge_sel = 2'd0;
    logic           iff_en = 1'b0;
    logic [CW-1:0]  delay_val = '0;
    logic           clr_drop = 1'b0;
    logic           fire;
    logic [FCW-1:0] fire_cnt;
    logic [PW-1:0]  pending;
    logic           drop;

    typedef struct {
        int exp_edge;
        bit slot;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    bit  sig_prev = 1'b0;
    bit  m_drop   = 1'b0;

    event_delay_scheduler #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .edge_sel  (edge_sel),
        .iff_en    (iff_en),
        .delay_val (delay_val),
        .clr_drop  (clr_drop),
        .fire      (fire),
        .fire_cnt  (fire_cnt),
        .pending   (pending),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit edge_match(input logic [1:0] sel, input bit cur, input bit prev);
        case (sel)
            S_POS:   return cur & ~prev;
            S_NEG:   return ~cur & prev;
            S_ANY:   return cur ^ prev;
            default: return 1'b0;
        endcase
    endfunction

    // Drives one edge worth of inputs, predicts the outcome, then checks all outputs after the edge.
    task automatic step(input bit s, input logic [1:0] sel, input bit en, input int d, input bit clr);
        int  n;
        int  occ;
        int  exp_fc;
        int  exp_pend;
        bit  acc;
        bit  disc;
        ev_t keep[$];
        sig_in    = s;
        edge_sel  = sel;
        iff_en    = en;
        delay_val = d[CW-1:0];
        clr_drop  = clr;
        n    = cyc + 1;
        acc  = en && edge_match(sel, s, sig_prev);
        occ  = 0;
        disc = 1'b0;
        foreach (q[i]) if (q[i].slot && q[i].exp_edge >= n) occ++;
        if (acc) begin
            if (d == 0) q.push_back('{n, 1'b0});
            else if (occ < DEPTH) q.push_back('{n + d, 1'b1});
            else disc = 1'b1;
        end
        if (disc) m_drop = 1'b1;
        else if (clr) m_drop = 1'b0;
        sig_prev = s;

        @(posedge clk);
        cyc++;
        #1;
        exp_fc   = 0;
        exp_pend = 0;
        foreach (q[i]) begin
            if (q[i].exp_edge == n) exp_fc++;
            else keep.push_back(q[i]);
        end
        q = keep;
        foreach (q[i]) if (q[i].slot) exp_pend++;
        chk("fire_cnt", 32'(fire_cnt), exp_fc);
        chk("fire", 32'(fire), (exp_fc != 0) ? 1 : 0);
        chk("pending", 32'(pending), exp_pend);
        chk("drop", 32'(drop), m_drop ? 1 : 0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(sig_prev, S_NONE, 1'b0, $urandom_range(0, 255), 1'b0);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_fire", 32'(fire), 0);
        chk("rst_fire_cnt", 32'(fire_cnt), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_drop", 32'(drop), 0);
        q.delete();
        m_drop   = 1'b0;
        sig_prev = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2;
        chk("init_fire", 32'(fire), 0);
        chk("init_fire_cnt", 32'(fire_cnt), 0);
        chk("init_pending", 32'(pending), 0);
        chk("init_drop", 32'(drop), 0);
        @(negedge clk);
        rst = 1'b1;

        // High input at first edge after release counts as a rising edge.
        step(1'b1, S_POS, 1'b1, 2, 1'b0);
        idle(4);
        step(1'b0, S_NONE, 1'b0, 0, 1'b0);
        idle(2);

        // POS with delay 3; delay_val wiggles afterwards.
        step(1'b1, S_POS, 1'b1, 3, 1'b0);
        step(1'b1, S_POS, 1'b1, 9, 1'b0);
        step(1'b1, S_POS, 1'b1, 1, 1'b0);
        step(1'b1, S_POS, 1'b1, 0, 1'b0);
        idle(2);

        // NEG with delay 0: immediate fire, no slot.
        step(1'b0, S_NEG, 1'b1, 0, 1'b0);
        idle(2);

        // ANY: delay 2 then delay 1 both expire at the same edge.
        step(1'b1, S_ANY, 1'b1, 2, 1'b0);
        step(1'b0, S_ANY, 1'b1, 1, 1'b0);
        idle(3);

        // Disqualified edges.
        step(1'b1, S_POS, 1'b0, 2, 1'b0);
        step(1'b0, S_NONE, 1'b1, 0, 1'b0);
        step(1'b1, S_NONE, 1'b1, 2, 1'b0);
        idle(4);
        step(1'b0, S_NONE, 1'b0, 0, 1'b0);

        // Fill all slots; the fifth discard coincides with clr_drop, then clear later.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, S_POS, 1'b1, 20, (k == 4));
            step(1'b0, S_POS, 1'b1, 20, 1'b0);
        end
        idle(2);
        step(sig_prev, S_NONE, 1'b0, 0, 1'b1);
        idle(20);

        // All four slots expire at the edge a new event arrives: it is discarded.
        step(1'b1, S_POS, 1'b1, 8, 1'b0);
        step(1'b0, S_POS, 1'b1, 0, 1'b0);
        step(1'b1, S_POS, 1'b1, 6, 1'b0);
        step(1'b0, S_POS, 1'b1, 0, 1'b0);
        step(1'b1, S_POS, 1'b1, 4, 1'b0);
        step(1'b0, S_POS, 1'b1, 0, 1'b0);
        step(1'b1, S_POS, 1'b1, 2, 1'b0);
        step(1'b0, S_POS, 1'b1, 0, 1'b0);
        step(1'b1, S_POS, 1'b1, 5, 1'b0);
        step(1'b1, S_POS, 1'b1, 1, 1'b0);
        step(1'b0, S_POS, 1'b1, 1, 1'b0);
        step(1'b1, S_POS, 1'b1, 1, 1'b1);
        idle(3);

        // Reset with three events pending; nothing may fire afterwards.
        step(1'b0, S_ANY, 1'b1, 10, 1'b0);
        step(1'b1, S_ANY, 1'b1, 10, 1'b0);
        step(1'b0, S_ANY, 1'b1, 10, 1'b0);
        do_reset();
        idle(30);

        // Random mix.
        for (int k = 0; k < 80; k++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 6),
                 ($urandom_range(0, 7) == 0));
        end
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
